// File: rtl/eth_state_rx.sv
// RMII receive deframer for the kart player-state link: preamble/SFD hunt,
// 24-dibit capture, XOR checksum validation and held opponent-state registers.
module eth_state_rx #(
    parameter int PRE_MIN = 4
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    input  logic [1:0]  eth_rxd,
    input  logic        eth_crsdv,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [2:0]  opp_stat,
    output logic        pkt_valid,
    output logic        pkt_err
);

    localparam int CW = (PRE_MIN < 1) ? 1 : $clog2(PRE_MIN + 1);
    localparam logic [CW-1:0] PRE_SAT = CW'(PRE_MIN);
    localparam logic [4:0] LAST_DIBIT = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] pre_cnt_r, pre_cnt_s;
    logic [4:0]    dib_cnt_r, dib_cnt_s;
    logic [47:0]   shift_r, shift_s;
    logic [10:0]   opp_x_r, opp_x_s;
    logic [10:0]   opp_y_r, opp_y_s;
    logic [8:0]    opp_dir_r, opp_dir_s;
    logic [2:0]    opp_stat_r, opp_stat_s;
    logic          pkt_valid_r, pkt_valid_s;
    logic          pkt_err_r, pkt_err_s;
    logic          cks_ok_s;

    // Checksum is the byte-wise XOR of the five payload bytes.
    function automatic logic [7:0] payload_xor(input logic [39:0] p);
        return p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24] ^ p[39:32];
    endfunction

    // Compare received checksum byte against the payload XOR.
    always_comb begin
        cks_ok_s = (shift_r[47:40] == payload_xor(shift_r[39:0]));
    end

    // Next-state, capture and strobe logic.
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        dib_cnt_s   = dib_cnt_r;
        shift_s     = shift_r;
        opp_x_s     = opp_x_r;
        opp_y_s     = opp_y_r;
        opp_dir_s   = opp_dir_r;
        opp_stat_s  = opp_stat_r;
        pkt_valid_s = 1'b0;
        pkt_err_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                pre_cnt_s = '0;
                dib_cnt_s = 5'd0;
                if (eth_crsdv && (eth_rxd == 2'b01)) begin
                    state_s   = ST_PRE;
                    pre_cnt_s = CW'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PRE: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                end else if (eth_rxd == 2'b01) begin
                    // Saturate so long preambles never wrap below PRE_MIN.
                    if (pre_cnt_r < PRE_SAT) begin
                        pre_cnt_s = pre_cnt_r + CW'(1);
                    end else begin
                        pre_cnt_s = pre_cnt_r;
                    end
                end else if ((eth_rxd == 2'b11) && (pre_cnt_r >= PRE_SAT)) begin
                    state_s   = ST_DATA;
                    dib_cnt_s = 5'd0;
                end else begin
                    state_s = ST_DROP;
                end
            end

            ST_DATA: begin
                // The final dibit is taken even if carrier drops with it.
                if (dib_cnt_r == LAST_DIBIT) begin
                    shift_s = {eth_rxd, shift_r[47:2]};
                    state_s = ST_CHECK;
                end else if (!eth_crsdv) begin
                    pkt_err_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    shift_s   = {eth_rxd, shift_r[47:2]};
                    dib_cnt_s = dib_cnt_r + 5'd1;
                end
            end

            ST_CHECK: begin
                if (cks_ok_s) begin
                    opp_x_s     = shift_r[10:0];
                    opp_y_s     = shift_r[21:11];
                    opp_dir_s   = shift_r[30:22];
                    opp_stat_s  = shift_r[33:31];
                    pkt_valid_s = 1'b1;
                end else begin
                    pkt_err_s = 1'b1;
                end
                if (eth_crsdv) begin
                    state_s = ST_DROP;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state_r     <= ST_IDLE;
            pre_cnt_r   <= '0;
            dib_cnt_r   <= 5'd0;
            shift_r     <= 48'd0;
            opp_x_r     <= 11'd0;
            opp_y_r     <= 11'd0;
            opp_dir_r   <= 9'd0;
            opp_stat_r  <= 3'd0;
            pkt_valid_r <= 1'b0;
            pkt_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            dib_cnt_r   <= dib_cnt_s;
            shift_r     <= shift_s;
            opp_x_r     <= opp_x_s;
            opp_y_r     <= opp_y_s;
            opp_dir_r   <= opp_dir_s;
            opp_stat_r  <= opp_stat_s;
            pkt_valid_r <= pkt_valid_s;
            pkt_err_r   <= pkt_err_s;
        end
    end

    assign opp_x     = opp_x_r;
    assign opp_y     = opp_y_r;
    assign opp_dir   = opp_dir_r;
    assign opp_stat  = opp_stat_r;
    assign pkt_valid = pkt_valid_r;
    assign pkt_err   = pkt_err_r;

endmodule

// File: tb/tb_eth_state_rx.sv
// Scoreboard bench for eth_state_rx: directed frames push expected strobes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_eth_state_rx;

    logic        eth_clk = 1'b0;
    logic        eth_rst = 1'b1;
    logic [1:0]  eth_rxd = 2'b00;
    logic        eth_crsdv = 1'b0;
    logic [10:0] opp_x;
    logic [10:0] opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_stat;
    logic        pkt_valid;
    logic        pkt_err;

    eth_state_rx #(.PRE_MIN(4)) dut (
        .eth_clk   (eth_clk),
        .eth_rst   (eth_rst),
        .eth_rxd   (eth_rxd),
        .eth_crsdv (eth_crsdv),
        .opp_x     (opp_x),
        .opp_y     (opp_y),
        .opp_dir   (opp_dir),
        .opp_stat  (opp_stat),
        .pkt_valid (pkt_valid),
        .pkt_err   (pkt_err)
    );

    always #10 eth_clk = ~eth_clk;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [2:0]  stat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_edge = 0;
    bit   done = 1'b0;

    // Hand-computed frames: {checksum, byte4 .. byte0}.
    localparam logic [47:0] FR_A     = 48'h5E_00_96_80_40_08; // x=8 y=8 dir=90 stat=1
    localparam logic [47:0] FR_A_BAD = 48'h5F_00_96_80_40_08;
    localparam logic [47:0] FR_B     = 48'h09_03_D9_D7_FB_FF; // x=1023 y=767 dir=359 stat=7
    localparam logic [47:0] FR_C     = 48'h5F_00_96_80_40_09; // x=9 y=8 dir=90 stat=1

    always @(posedge eth_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dibr(input logic rst, input logic cv, input logic [1:0] d);
        @(negedge eth_clk);
        eth_rst   = rst;
        eth_crsdv = cv;
        eth_rxd   = d;
        last_edge = cyc + 1;
    endtask

    task automatic dib(input logic cv, input logic [1:0] d);
        dibr(1'b0, cv, d);
    endtask

    task automatic send(input int npre, input logic [47:0] fr, input int ndib);
        logic [47:0] f;
        f = fr;
        for (int i = 0; i < npre; i++) dib(1'b1, 2'b01);
        dib(1'b1, 2'b11);
        for (int i = 0; i < ndib; i++) dib(1'b1, f[2*i +: 2]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) dib(1'b0, 2'b00);
    endtask

    task automatic push(input bit is_err, input int c, input logic [10:0] x,
                        input logic [10:0] y, input logic [8:0] dir, input logic [2:0] stat);
        exp_t e;
        e.is_err = is_err; e.cyc = c; e.x = x; e.y = y; e.dir = dir; e.stat = stat;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge eth_clk) begin
        exp_t e;
        if (pkt_valid && pkt_err) begin
            tests++; fails++;
            $display("FAIL both_strobes: cycle %0d valid and err both high", cyc);
        end else if (pkt_valid || pkt_err) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: cycle %0d valid=%b err=%b, none expected",
                         cyc, pkt_valid, pkt_err);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err != pkt_err || e.cyc != cyc || opp_x !== e.x || opp_y !== e.y ||
                    opp_dir !== e.dir || opp_stat !== e.stat) begin
                    fails++;
                    $display("FAIL strobe: got err=%b cyc=%0d x=%0d y=%0d dir=%0d stat=%0d expected err=%b cyc=%0d x=%0d y=%0d dir=%0d stat=%0d",
                             pkt_err, cyc, opp_x, opp_y, opp_dir, opp_stat,
                             e.is_err, e.cyc, e.x, e.y, e.dir, e.stat);
                end
            end
        end
    end

    initial begin
        repeat (4) @(negedge eth_clk);
        check("reset_outputs", {30'd0, opp_x, opp_y, opp_dir, opp_stat, pkt_valid, pkt_err}, 64'd0);
        dib(1'b0, 2'b00);
        idle(2);

        // Bad checksum right after reset: error, outputs stay zero.
        send(8, FR_A_BAD, 24);
        push(1'b1, last_edge + 1, 11'd0, 11'd0, 9'd0, 3'd0);
        idle(3);
        check("bad_cks_hold", {opp_x, opp_y, opp_dir, opp_stat}, 34'd0);

        // Good frame A.
        send(8, FR_A, 24);
        push(1'b0, last_edge + 1, 11'd8, 11'd8, 9'd90, 3'd1);
        idle(3);
        check("good_a_held", {opp_x, opp_y, opp_dir, opp_stat}, {11'd8, 11'd8, 9'd90, 3'd1});

        // Short preamble: silently dropped.
        send(3, FR_A, 24);
        idle(3);
        check("short_pre_hold", {opp_x, opp_y, opp_dir, opp_stat}, {11'd8, 11'd8, 9'd90, 3'd1});

        // Carrier lost after payload dibit 10.
        send(8, FR_B, 11);
        dib(1'b0, 2'b00);
        push(1'b1, last_edge, 11'd8, 11'd8, 9'd90, 3'd1);
        idle(3);

        // Good frame B with exactly PRE_MIN preamble dibits.
        send(4, FR_B, 24);
        push(1'b0, last_edge + 1, 11'd1023, 11'd767, 9'd359, 3'd7);
        idle(3);
        check("good_b_held", {opp_x, opp_y, opp_dir, opp_stat}, {11'd1023, 11'd767, 9'd359, 3'd7});

        // Back-to-back frames with a single idle cycle.
        send(4, FR_A, 24);
        push(1'b0, last_edge + 1, 11'd8, 11'd8, 9'd90, 3'd1);
        idle(1);
        send(4, FR_C, 24);
        push(1'b0, last_edge + 1, 11'd9, 11'd8, 9'd90, 3'd1);
        idle(3);
        check("b2b_second_held", {21'd0, opp_x}, {21'd0, 11'd9});

        // Reset during payload dibit 12; remainder must not be accepted.
        send(8, FR_A, 12);
        dibr(1'b1, 1'b1, FR_A[25:24]);
        for (int i = 13; i < 24; i++) dib(1'b1, FR_A[2*i +: 2]);
        idle(3);
        check("mid_reset_outputs", {30'd0, opp_x, opp_y, opp_dir, opp_stat, pkt_valid, pkt_err}, 64'd0);

        // Recovery after reset.
        send(8, FR_B, 24);
        push(1'b0, last_edge + 1, 11'd1023, 11'd767, 9'd359, 3'd7);
        idle(4);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (5000) @(posedge eth_clk);
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: cycle %0d reached, stimulus not complete", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

endmodule

// File: doc/eth_state_rx.md
# eth_state_rx

Receive-side RMII deframer on the Ethernet link between the two kart boards. It consumes the dibit stream produced by the peer board's `transmit` stage: preamble/SFD, then a 5-byte player-state payload and a 1-byte checksum. It validates each frame and presents the opponent's position, direction and game status to the game logic as held registers, with a one-cycle `pkt_valid` strobe per accepted frame.

## Interface
- `PRE_MIN`, default 4: minimum count of consecutive `2'b01` dibits required before the SFD dibit.
- `eth_clk`  in  1  50 MHz RMII reference clock; the only clock.
- `eth_rst`  in  1  synchronous reset, active high.
- `eth_rxd`  in  2  RMII receive dibit, LSB-first within each byte.
- `eth_crsdv`  in  1  carrier sense / data valid.
- `opp_x`  out  11  opponent x position, last accepted frame.
- `opp_y`  out  11  opponent y position.
- `opp_dir`  out  9  opponent direction, degrees.
- `opp_stat`  out  3  opponent game status.
- `pkt_valid`  out  1  one-cycle strobe when the outputs update.
- `pkt_err`  out  1  one-cycle strobe when a frame is rejected after its SFD.

## Operation
- Sampling: `eth_rxd` and `eth_crsdv` are sampled on every rising edge of `eth_clk`; one dibit per cycle.
- Frame on the wire: ≥`PRE_MIN` dibits `01`, SFD dibit `11`, 20 payload dibits, 4 checksum dibits.
- Payload word P[39:0], byte 0 first, each byte LSB dibit first: P[10:0]=x, P[21:11]=y, P[30:22]=dir, P[33:31]=stat, P[39:34] ignored.
- Checksum byte = XOR of payload bytes 0..4.
- State machine:
  - IDLE: preamble counter cleared. `crsdv=1 & rxd=01` → PRE, count=1.
  - PRE: `rxd=01` increments the counter, saturating at `PRE_MIN`. `rxd=11` with count≥`PRE_MIN` → DATA, dibit counter=0. `rxd=11` with count<`PRE_MIN`, any other dibit, or `crsdv=0` → DROP (or IDLE if `crsdv=0`). No `pkt_err` is raised in this state.
  - DATA: shifts 24 dibits into a 48-bit shift register. After the 24th dibit → CHECK. `crsdv=0` before the 24th dibit → `pkt_err` pulse, then IDLE.
  - CHECK (1 cycle): checksum match → load `opp_*`, `pkt_valid`=1. Mismatch → `pkt_err`=1, outputs hold. Next state is DROP if `crsdv=1`, otherwise IDLE.
  - DROP: ignores all dibits until `crsdv=0`, then IDLE.
- `opp_*` change only on an accepted frame and hold between frames.
- `pkt_valid` and `pkt_err` are never high in the same cycle.

## Timing
- Reset: `opp_x`, `opp_y`, `opp_dir`, `opp_stat`, `pkt_valid` and `pkt_err` are all 0; state is IDLE; counters and shift register are cleared.
- Reset applied mid-frame aborts the frame with no strobe. The remainder of that frame is not accepted, because the next valid SFD requires a fresh preamble.
- Latency: the CHECK cycle follows the edge that samples the last checksum dibit. `opp_*` and `pkt_valid` are visible from the next edge after that, i.e. 2 edges after the final dibit.
- A frame of `PRE_MIN`+1+24 dibits followed by `crsdv` low for 1 cycle is enough to accept the next frame immediately.
- `crsdv` falling on the same edge as the 24th dibit is not a drop: the dibit is taken, then CHECK runs.
- Preamble longer than `PRE_MIN` is accepted; the counter saturates and does not wrap.

## Test plan
- Good frame (8 × `01`, `11`, payload x=8, y=8, dir=90, stat=1, bytes 08 40 80 96 00, checksum 5E) → `pkt_valid` for 1 cycle, 2 edges after the last dibit; `opp_x`=8, `opp_y`=8, `opp_dir`=90, `opp_stat`=1; `pkt_err`=0 throughout.
- Same frame with checksum 5F → `pkt_err` pulse for 1 cycle; `opp_*` keep their previous values (0 after reset).
- Preamble of 3 × `01` then `11` with the good payload → no `pkt_valid`, no `pkt_err`; state returns to IDLE after `crsdv` falls.
- `crsdv` dropped after payload dibit 10 → `pkt_err` pulse; following good frame with x=1023, y=767, dir=359, stat=7 → outputs update to those values.
- Two good frames 1 idle cycle apart (x=8 then x=9) → two `pkt_valid` pulses; `opp_x`=8 then 9.
- `eth_rst` asserted for 1 cycle during payload dibit 12 → all outputs 0, no strobe; the rest of that frame is not accepted.
